// File: rtl/stall_ctrl_multi_if.sv
// Handshake bundle between the pipeline hazard sources and the stall controller.
// The controller takes the slave side; whoever drives the requests takes master.
interface stall_ctrl_multi_if #(
    parameter int NUM_STAGES = 5,
    parameter int PERF_W     = 16
);
    logic                  id_stop;
    logic                  mem_stop_end;
    logic                  ex_stop;
    logic                  flush_req;
    logic [NUM_STAGES-1:0] stall;
    logic                  flush;
    logic                  busy;
    logic                  timeout_err;
    logic [PERF_W-1:0]     perf_stall_cnt;

    modport master (
        output id_stop, mem_stop_end, ex_stop, flush_req,
        input  stall, flush, busy, timeout_err, perf_stall_cnt
    );

    modport slave (
        input  id_stop, mem_stop_end, ex_stop, flush_req,
        output stall, flush, busy, timeout_err, perf_stall_cnt
    );
endinterface

// File: rtl/stall_ctrl_multi.sv
// Pipeline stall controller: arbitrates load-use, multicycle-EX and flush requests
// into a registered per-stage stall vector, with a saturating stall-cycle counter.
module stall_ctrl_multi #(
    parameter int          NUM_STAGES      = 5,
    parameter int          HOLD_CYCLES     = 4,
    parameter int          RELEASE_MODE    = 0,
    parameter logic [31:0] LOAD_STALL_MASK = 32'b00011,
    parameter logic [31:0] EX_STALL_MASK   = 32'b00111,
    parameter int          PERF_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    stall_ctrl_multi_if.slave  bus
);
    localparam int              CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam bit              MODE1      = (RELEASE_MODE == 1);

    typedef enum logic [1:0] {IDLE, LOAD_HOLD, EX_HOLD} state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  load_pend_reg, load_pend_next;
    logic [NUM_STAGES-1:0] stall_reg, stall_next;
    logic                  flush_reg, flush_next;
    logic                  timeout_reg, timeout_next;
    logic [PERF_W-1:0]     perf_reg;
    logic [NUM_STAGES-1:0] load_mask, ex_mask;
    logic                  mem_release;

    // Only the low NUM_STAGES mask bits name real stages.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
            assign load_mask[gi] = LOAD_STALL_MASK[gi];
            assign ex_mask[gi]   = EX_STALL_MASK[gi];
        end
    endgenerate

    assign mem_release = MODE1 && bus.mem_stop_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            load_pend_reg <= 1'b0;
            stall_reg     <= '0;
            flush_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
            perf_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            load_pend_reg <= load_pend_next;
            stall_reg     <= stall_next;
            flush_reg     <= flush_next;
            timeout_reg   <= timeout_next;
            if (stall_reg != '0 && perf_reg != {PERF_W{1'b1}})
                perf_reg <= perf_reg + 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        load_pend_next = load_pend_reg;
        if (bus.flush_req) begin
            state_next     = IDLE;
            cnt_next       = '0;
            load_pend_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (bus.ex_stop) begin
                        state_next = EX_HOLD;
                    end else if (bus.id_stop) begin
                        state_next = LOAD_HOLD;
                        cnt_next   = CNT_RELOAD;
                    end
                end
                LOAD_HOLD: begin
                    if (bus.ex_stop) begin
                        state_next     = EX_HOLD;
                        load_pend_next = 1'b1;
                    end else if (bus.id_stop) begin
                        cnt_next = CNT_RELOAD;
                    end else if (mem_release || cnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                EX_HOLD: begin
                    if (mem_release)
                        load_pend_next = 1'b0;
                    // A new load-use hazard wins over a same-edge MEM release.
                    if (bus.id_stop) begin
                        load_pend_next = 1'b1;
                        cnt_next       = CNT_RELOAD;
                    end
                    if (!bus.ex_stop) begin
                        state_next     = load_pend_next ? LOAD_HOLD : IDLE;
                        load_pend_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        flush_next   = bus.flush_req;
        timeout_next = MODE1 && !bus.flush_req && state_reg == LOAD_HOLD &&
                       !bus.ex_stop && !bus.id_stop && !mem_release && cnt_reg == '0;
        unique case (state_next)
            LOAD_HOLD: stall_next = load_mask;
            EX_HOLD:   stall_next = ex_mask;
            default:   stall_next = '0;
        endcase
    end

    assign bus.stall          = stall_reg;
    assign bus.flush          = flush_reg;
    assign bus.busy           = (state_reg != IDLE);
    assign bus.timeout_err    = timeout_reg;
    assign bus.perf_stall_cnt = perf_reg;
endmodule

// File: tb/tb_stall_ctrl_multi.sv
// Randomised bench for stall_ctrl_multi: three instances (fixed-length, MEM-released,
// 4-bit perf counter) share stimulus and are compared against a remaining-cycles model.
module tb_stall_ctrl_multi;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    logic id_stop, mem_stop_end, ex_stop, flush_req;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stall_ctrl_multi_if #(.NUM_STAGES(5), .PERF_W(16)) b0 ();
    stall_ctrl_multi_if #(.NUM_STAGES(5), .PERF_W(16)) b1 ();
    stall_ctrl_multi_if #(.NUM_STAGES(5), .PERF_W(4))  b2 ();

    assign b0.id_stop = id_stop;  assign b0.mem_stop_end = mem_stop_end;
    assign b0.ex_stop = ex_stop;  assign b0.flush_req    = flush_req;
    assign b1.id_stop = id_stop;  assign b1.mem_stop_end = mem_stop_end;
    assign b1.ex_stop = ex_stop;  assign b1.flush_req    = flush_req;
    assign b2.id_stop = id_stop;  assign b2.mem_stop_end = mem_stop_end;
    assign b2.ex_stop = ex_stop;  assign b2.flush_req    = flush_req;

    stall_ctrl_multi #(.HOLD_CYCLES(HOLD), .RELEASE_MODE(0), .PERF_W(16))
        u_d0 (.clk(clk), .rst(rst), .bus(b0));
    stall_ctrl_multi #(.HOLD_CYCLES(HOLD), .RELEASE_MODE(1), .PERF_W(16))
        u_d1 (.clk(clk), .rst(rst), .bus(b1));
    stall_ctrl_multi #(.HOLD_CYCLES(HOLD), .RELEASE_MODE(0), .PERF_W(4))
        u_d2 (.clk(clk), .rst(rst), .bus(b2));

    // Reference: kind 0=idle, 1=load hold, 2=EX hold; left = load-hold cycles still owed.
    typedef struct {
        int kind;
        int left;
        bit pend;
        bit flush;
        bit tmo;
        int perf;
    } mdl_t;

    mdl_t mdl [3];
    bit   mdl_mode1 [3] = '{1'b0, 1'b1, 1'b0};
    int   mdl_pmax  [3] = '{65535, 65535, 15};

    function automatic logic [4:0] mdl_stall(int kind);
        if (kind == 1) return 5'b00011;
        if (kind == 2) return 5'b00111;
        return 5'b00000;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit mode1, int pmax,
                                      bit id, bit mem, bit ex, bit fl);
        mdl_t n = m;
        n.flush = 1'b0;
        n.tmo   = 1'b0;
        if (mdl_stall(m.kind) != 5'b0 && m.perf < pmax) n.perf = m.perf + 1;
        if (fl) begin
            n.kind = 0; n.pend = 1'b0; n.flush = 1'b1;
        end else if (m.kind == 0) begin
            if (ex)      n.kind = 2;
            else if (id) begin n.kind = 1; n.left = HOLD; end
        end else if (m.kind == 1) begin
            if (ex)                 begin n.kind = 2; n.pend = 1'b1; end
            else if (id)            n.left = HOLD;
            else if (mode1 && mem)  n.kind = 0;
            else if (m.left <= 1)   begin n.kind = 0; n.tmo = mode1; end
            else                    n.left = m.left - 1;
        end else begin
            if (mode1 && mem) n.pend = 1'b0;
            if (id) begin n.pend = 1'b1; n.left = HOLD; end
            if (!ex) begin n.kind = n.pend ? 1 : 0; n.pend = 1'b0; end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input int i, input logic [4:0] st, input logic fl,
                           input logic bz, input logic tm, input logic [15:0] pf);
        chk($sformatf("d%0d.stall", i),   {27'b0, st}, {27'b0, mdl_stall(mdl[i].kind)});
        chk($sformatf("d%0d.flush", i),   {31'b0, fl}, {31'b0, mdl[i].flush});
        chk($sformatf("d%0d.busy", i),    {31'b0, bz}, {31'b0, mdl[i].kind != 0});
        chk($sformatf("d%0d.timeout", i), {31'b0, tm}, {31'b0, mdl[i].tmo});
        chk($sformatf("d%0d.perf", i),    {16'b0, pf}, mdl[i].perf);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic tick(input bit r, input bit id, input bit mem, input bit ex, input bit fl);
        rst = r; id_stop = id; mem_stop_end = mem; ex_stop = ex; flush_req = fl;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (r) mdl[i] = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
            else   mdl[i] = mdl_step(mdl[i], mdl_mode1[i], mdl_pmax[i], id, mem, ex, fl);
        end
        #1;
        chk_dut(0, b0.stall, b0.flush, b0.busy, b0.timeout_err, b0.perf_stall_cnt);
        chk_dut(1, b1.stall, b1.flush, b1.busy, b1.timeout_err, b1.perf_stall_cnt);
        chk_dut(2, b2.stall, b2.flush, b2.busy, b2.timeout_err, {12'b0, b2.perf_stall_cnt});
        $display("cyc rst=%0b id=%0b mem=%0b ex=%0b fl=%0b | d0 st=%b d1 st=%b tmo=%0b d2 pf=%0d",
                 r, id, mem, ex, fl, b0.stall, b1.stall, b1.timeout_err, b2.perf_stall_cnt);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; id_stop = 0; mem_stop_end = 0; ex_stop = 0; flush_req = 0;
        for (int i = 0; i < 3; i++) mdl[i] = '{0, 0, 1'b0, 1'b0, 1'b0, 0};

        // Reset state
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("rst.stall", {27'b0, b0.stall}, 32'd0);

        // Fixed-length load stall: four cycles, counter ends at 4
        tick(0, 1, 0, 0, 0);
        chk("t1.stall_e0", {27'b0, b0.stall}, 32'b00011);
        idle(3);
        chk("t1.stall_e3", {27'b0, b0.stall}, 32'b00011);
        idle(1);
        chk("t1.stall_e4", {27'b0, b0.stall}, 32'd0);
        chk("t1.perf", {16'b0, b0.perf_stall_cnt}, 32'd4);

        // Re-trigger at edge 2 stretches to six cycles
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0); idle(1); tick(0, 1, 0, 0, 0); idle(3);
        chk("t2.busy_e5", {31'b0, b0.busy}, 32'd1);
        idle(1);
        chk("t2.busy_e6", {31'b0, b0.busy}, 32'd0);

        // MEM-released load: early release, then timeout
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0); idle(1); tick(0, 0, 1, 0, 0);
        chk("t3.release", {27'b0, b1.stall}, 32'd0);
        chk("t3.no_tmo", {31'b0, b1.timeout_err}, 32'd0);
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0); idle(4);
        chk("t3.tmo", {31'b0, b1.timeout_err}, 32'd1);
        idle(1);

        // EX stall overlaying a load stall
        tick(1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0); tick(0, 0, 0, 1, 0); tick(0, 0, 0, 1, 0);
        chk("t4.ex", {27'b0, b0.stall}, 32'b00111);
        idle(4);
        chk("t4.load_e7", {27'b0, b0.stall}, 32'b00011);
        idle(1);
        chk("t4.idle_e8", {27'b0, b0.stall}, 32'd0);

        // Flush wins over same-edge id_stop; reset mid-hold
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 0, 1);
        chk("t5.flush", {31'b0, b0.flush}, 32'd1);
        chk("t5.busy", {31'b0, b0.busy}, 32'd0);
        tick(0, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        chk("t5.rst", {27'b0, b0.stall}, 32'd0);

        // Saturation of the 4-bit counter
        for (int k = 0; k < 20; k++) tick(0, 0, 0, 1, 0);
        idle(1);
        chk("t6.sat", {28'b0, b2.perf_stall_cnt}, 32'd15);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0) || (ex_stop && $urandom_range(0, 2) != 0),
                 ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
